// File: rtl/full_adder_pkg.sv
// Shared constants and types for the registered ripple-carry full adder.
package full_adder_pkg;

  localparam int FA_MAX_WIDTH = 64;

  typedef struct packed {
    logic cout;
    logic sum;
  } fa_pair_t;

  function automatic fa_pair_t fa_eval(input logic a, input logic b, input logic c);
    fa_pair_t r;
    r.sum  = a ^ b ^ c;
    r.cout = (a & b) | (a & c) | (b & c);
    return r;
  endfunction

endpackage

// File: rtl/full_adder_bit.sv
// Purely combinational 1-bit full-adder cell; the leaf of the ripple chain.
module full_adder_bit
  import full_adder_pkg::*;
(
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  fa_pair_t pair;

  assign pair   = fa_eval(a_i, b_i, cin_i);
  assign sum_o  = pair.sum;
  assign cout_o = pair.cout;

endmodule

// File: rtl/full_adder_core.sv
// Registered WIDTH-bit ripple-carry adder, 1-cycle latency, no backpressure.
// Define FULL_ADDER_OVERFLOW_EN to add the registered signed-overflow output ovf.
module full_adder_core
  import full_adder_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef FULL_ADDER_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  // c[i] is the carry into bit i; c[WIDTH] is the carry out.
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = cin;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    full_adder_bit u_bit (
      .a_i   (a[gi]),
      .b_i   (b[gi]),
      .cin_i (c[gi]),
      .sum_o (s[gi]),
      .cout_o(c[gi+1])
    );
  end

  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             valid_q, valid_d;

  // Capture only when in_valid, so undriven operands while idle never reach the registers.
  always_comb begin
    sum_d   = sum_q;
    cout_d  = cout_q;
    valid_d = in_valid;
    if (in_valid) begin
      sum_d  = s;
      cout_d = c[WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      valid_q <= valid_d;
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign out_valid = valid_q;

`ifdef FULL_ADDER_OVERFLOW_EN
  logic ovf_q, ovf_d;

  // Signed overflow: carry into the sign bit differs from carry out of it.
  always_comb begin
    ovf_d = ovf_q;
    if (in_valid) ovf_d = c[WIDTH] ^ c[WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_full_adder_core.sv
// Directed self-checking bench: one WIDTH=1 instance and one WIDTH=8 instance.
// Overflow checks run only when FULL_ADDER_OVERFLOW_EN is defined.
module tb_full_adder_core;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       v1 = 1'b0, a1 = 1'b0, b1 = 1'b0, c1 = 1'b0;
  logic       ov1, s1, co1;
  logic       v8 = 1'b0, c8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       ov8, co8;
  logic [7:0] s8;
`ifdef FULL_ADDER_OVERFLOW_EN
  logic       ovf1, ovf8;
`endif

  int checks = 0;
  int failures = 0;

  logic [1:0] tt [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

  always #5 clk = ~clk;

  full_adder_core #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .cin(c1),
    .out_valid(ov1), .sum(s1), .cout(co1)
`ifdef FULL_ADDER_OVERFLOW_EN
    , .ovf(ovf1)
`endif
  );

  full_adder_core #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .a(a8), .b(b8), .cin(c8),
    .out_valid(ov8), .sum(s8), .cout(co8)
`ifdef FULL_ADDER_OVERFLOW_EN
    , .ovf(ovf8)
`endif
  );

  task automatic test_reset();
    v8 = 1'b1; a8 = 8'hFF; b8 = 8'h01;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ov1, co1, s1} !== 3'b000) begin
      failures++;
      $display("FAIL reset_w1 got v/c/s=%b expected 000", {ov1, co1, s1});
    end
    checks++;
    if ({ov8, co8, s8} !== 10'h000) begin
      failures++;
      $display("FAIL reset_w8 got v=%b c=%b s=%h expected 0/0/00", ov8, co8, s8);
    end
    $display("reset: w1 v/c/s=%b w8 v=%b c=%b s=%h", {ov1, co1, s1}, ov8, co8, s8);
    @(negedge clk);
    v8 = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_truth_table();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      v1 = 1'b1; {a1, b1, c1} = 3'(i);
      @(posedge clk); #1;
      checks++;
      if ({ov1, co1, s1} !== {1'b1, tt[i]}) begin
        failures++;
        $display("FAIL truth_%0d got v/c/s=%b expected %b", i, {ov1, co1, s1}, {1'b1, tt[i]});
      end
      $display("w1 abc=%03b -> cout/sum=%b%b", 3'(i), co1, s1);
    end
    @(negedge clk);
    v1 = 1'b0;
  endtask

  task automatic test_boundary();
    logic [7:0] ta [3] = '{8'hFF, 8'hFF, 8'h00};
    logic [7:0] tb [3] = '{8'h01, 8'hFF, 8'h00};
    logic       tc [3] = '{1'b0, 1'b1, 1'b0};
    logic [8:0] te [3] = '{9'h100, 9'h1FF, 9'h000};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      v8 = 1'b1; a8 = ta[i]; b8 = tb[i]; c8 = tc[i];
      @(posedge clk); #1;
      checks++;
      if ({ov8, co8, s8} !== {1'b1, te[i]}) begin
        failures++;
        $display("FAIL boundary_%0d got v=%b c=%b s=%h expected 1/%b/%h", i, ov8, co8, s8, te[i][8], te[i][7:0]);
      end
      $display("w8 %h+%h+%b -> c=%b s=%h", ta[i], tb[i], tc[i], co8, s8);
    end
    @(negedge clk);
    v8 = 1'b0;
  endtask

  task automatic test_hold();
    @(negedge clk);
    v8 = 1'b1; a8 = 8'h12; b8 = 8'h34; c8 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({ov8, co8, s8} !== {1'b1, 1'b0, 8'h47}) begin
      failures++;
      $display("FAIL hold_load got v=%b c=%b s=%h expected 1/0/47", ov8, co8, s8);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      v8 = 1'b0; a8 = (i == 1) ? 8'hxx : 8'(8'hA0 + i); b8 = 8'(8'h5F - i); c8 = (i == 2) ? 1'bx : 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({ov8, co8, s8} !== {1'b0, 1'b0, 8'h47}) begin
        failures++;
        $display("FAIL hold_%0d got v=%b c=%b s=%h expected 0/0/47", i, ov8, co8, s8);
      end
      $display("hold cycle %0d: v=%b c=%b s=%h", i, ov8, co8, s8);
    end
    @(negedge clk);
    a8 = '0; b8 = '0; c8 = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    v8 = 1'b1; a8 = 8'hFF; b8 = 8'h01; c8 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({ov8, co8, s8} !== {1'b1, 1'b1, 8'h00}) begin
      failures++;
      $display("FAIL rstmid_load got v=%b c=%b s=%h expected 1/1/00", ov8, co8, s8);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({ov8, co8, s8} !== 10'h000) begin
      failures++;
      $display("FAIL rstmid_async got v=%b c=%b s=%h expected 0/0/00", ov8, co8, s8);
    end
    @(posedge clk); #1;
    checks++;
    if ({ov8, co8, s8} !== 10'h000) begin
      failures++;
      $display("FAIL rstmid_held got v=%b c=%b s=%h expected 0/0/00", ov8, co8, s8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    a8 = 8'h10; b8 = 8'h20; c8 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({ov8, co8, s8} !== {1'b1, 1'b0, 8'h31}) begin
      failures++;
      $display("FAIL rstmid_after got v=%b c=%b s=%h expected 1/0/31", ov8, co8, s8);
    end
    $display("reset mid-op: after release c=%b s=%h", co8, s8);
    @(negedge clk);
    v8 = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      v8 = 1'b1;
      a8 = 8'($urandom_range(0, 255));
      b8 = 8'($urandom_range(0, 255));
      c8 = 1'($urandom_range(0, 1));
      exp = {1'b0, a8} + {1'b0, b8} + {8'h00, c8};
      @(posedge clk); #1;
      checks++;
      if ({ov8, co8, s8} !== {1'b1, exp}) begin
        failures++;
        $display("FAIL b2b_%0d got v=%b c=%b s=%h expected 1/%b/%h", i, ov8, co8, s8, exp[8], exp[7:0]);
      end
      $display("b2b %0d: %h+%h+%b -> c=%b s=%h", i, a8, b8, c8, co8, s8);
    end
    @(negedge clk);
    v8 = 1'b0;
  endtask

`ifdef FULL_ADDER_OVERFLOW_EN
  task automatic test_overflow();
    logic [7:0] ta [3] = '{8'h7F, 8'h80, 8'h01};
    logic [7:0] tb [3] = '{8'h01, 8'h80, 8'h01};
    logic [9:0] te [3] = '{{1'b1, 1'b0, 8'h80}, {1'b1, 1'b1, 8'h00}, {1'b0, 1'b0, 8'h02}};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      v8 = 1'b1; a8 = ta[i]; b8 = tb[i]; c8 = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({ovf8, co8, s8} !== te[i]) begin
        failures++;
        $display("FAIL ovf_%0d got ovf=%b c=%b s=%h expected %b/%b/%h", i, ovf8, co8, s8, te[i][9], te[i][8], te[i][7:0]);
      end
      $display("ovf %h+%h -> ovf=%b c=%b s=%h", ta[i], tb[i], ovf8, co8, s8);
    end
    @(negedge clk);
    v8 = 1'b0; a8 = 8'h7F; b8 = 8'h7F;
    @(posedge clk); #1;
    checks++;
    if (ovf8 !== 1'b0) begin
      failures++;
      $display("FAIL ovf_hold got ovf=%b expected 0", ovf8);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_truth_table();
    test_boundary();
    test_hold();
    test_reset_mid();
    test_back_to_back();
`ifdef FULL_ADDER_OVERFLOW_EN
    test_overflow();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
